// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - register-file writeback arbiter with zeroing sweep and stall counter
module rf_wb_arbiter #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            init_req,
  output logic            init_busy,
  input  logic            a_valid,
  input  logic [AW-1:0]   a_addr,
  input  logic [XLEN-1:0] a_data,
  output logic            a_ready,
  input  logic            b_valid,
  input  logic [AW-1:0]   b_addr,
  input  logic [XLEN-1:0] b_data,
  output logic            b_ready,
  output logic            we2,
  output logic [AW-1:0]   wa3,
  output logic [XLEN-1:0] wd3,
  output logic [15:0]     stall_cnt
);

  typedef enum logic {INIT, RUN} state_t;

  localparam logic [AW-1:0] IDX_FIRST = AW'(1);
  localparam logic [AW-1:0] IDX_LAST  = '1;

  state_t        state, state_nxt;
  logic [AW-1:0] idx, idx_nxt;
  logic          last_grant;   // 1 = B was granted last, so A wins the next tie
  logic          grant_a, grant_b, xfer;
  logic [AW-1:0]   sel_addr;
  logic [XLEN-1:0] sel_data;
  logic          blocked;

  // Round-robin grant; nothing is granted while the sweep owns the write port
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (state == RUN) begin
      if (a_valid && b_valid) begin
        if (last_grant) grant_a = 1'b1;
        else            grant_b = 1'b1;
      end else if (a_valid) begin
        grant_a = 1'b1;
      end else if (b_valid) begin
        grant_b = 1'b1;
      end
    end
  end

  assign a_ready   = grant_a;
  assign b_ready   = grant_b;
  assign xfer      = grant_a | grant_b;
  assign sel_addr  = grant_b ? b_addr : a_addr;
  assign sel_data  = grant_b ? b_data : a_data;
  assign init_busy = (state == INIT);
  assign blocked   = (state == RUN) && ((a_valid && !grant_a) || (b_valid && !grant_b));

  // Next-state logic: sweep 1..last then run; init_req only honoured in RUN
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      INIT: begin
        if (idx == IDX_LAST) begin
          state_nxt = RUN;
          idx_nxt   = IDX_FIRST;
        end else begin
          idx_nxt = idx + AW'(1);
        end
      end
      RUN: begin
        if (init_req) begin
          state_nxt = INIT;
          idx_nxt   = IDX_FIRST;
        end
      end
      default: begin
        state_nxt = INIT;
        idx_nxt   = IDX_FIRST;
      end
    endcase
  end

  // State and sweep index registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= INIT;
      idx   <= IDX_FIRST;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // Round-robin memory: flips on every accepted transfer, including address 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (xfer) begin
      last_grant <= grant_b;
    end
  end

  // Registered write port: sweep zeroes, granted writes land one cycle later, x0 is dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we2 <= 1'b0;
      wa3 <= '0;
      wd3 <= '0;
    end else if (state == INIT) begin
      we2 <= 1'b1;
      wa3 <= idx;
      wd3 <= '0;
    end else if (xfer && (sel_addr != '0)) begin
      we2 <= 1'b1;
      wa3 <= sel_addr;
      wd3 <= sel_data;
    end else begin
      we2 <= 1'b0;
    end
  end

  // Saturating count of RUN cycles in which any requester waited
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (blocked && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - directed bench for rf_wb_arbiter
module tb_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        init_req;
  logic        init_busy;
  logic        a_valid, b_valid;
  logic [4:0]  a_addr, b_addr;
  logic [31:0] a_data, b_data;
  logic        a_ready, b_ready;
  logic        we2;
  logic [4:0]  wa3;
  logic [31:0] wd3;
  logic [15:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  logic [31:0] rf [32];

  typedef struct {
    logic        av;
    logic [4:0]  aa;
    logic [31:0] ad;
    logic        bv;
    logic [4:0]  ba;
    logic [31:0] bd;
    logic        ear;
    logic        ebr;
    logic        ewe;
    logic [4:0]  ewa;
    logic [31:0] ewd;
    logic        chk_data;
  } vec_t;

  vec_t vecs [13];

  rf_wb_arbiter #(.XLEN(32), .AW(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .init_req  (init_req),
    .init_busy (init_busy),
    .a_valid   (a_valid),
    .a_addr    (a_addr),
    .a_data    (a_data),
    .a_ready   (a_ready),
    .b_valid   (b_valid),
    .b_addr    (b_addr),
    .b_data    (b_data),
    .b_ready   (b_ready),
    .we2       (we2),
    .wa3       (wa3),
    .wd3       (wd3),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  // Mock register file fed by the write port
  always @(posedge clk) begin
    if (we2) rf[wa3] <= wd3;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                              input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                              input logic ear, input logic ebr, input logic ewe,
                              input logic [4:0] ewa, input logic [31:0] ewd, input logic cd);
    vec_t v;
    v.av = av; v.aa = aa; v.ad = ad; v.bv = bv; v.ba = ba; v.bd = bd;
    v.ear = ear; v.ebr = ebr; v.ewe = ewe; v.ewa = ewa; v.ewd = ewd; v.chk_data = cd;
    return v;
  endfunction

  task automatic drive(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                       input logic bv, input logic [4:0] ba, input logic [31:0] bd);
    a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
  endtask

  initial begin
    int exp_stall;
    vecs[0]  = mk(1, 3, 32'h30,   1, 4, 32'h40,   1, 0, 1, 3,  32'h30,   1);
    vecs[1]  = mk(1, 3, 32'h31,   1, 4, 32'h40,   0, 1, 1, 4,  32'h40,   1);
    vecs[2]  = mk(1, 3, 32'h31,   1, 4, 32'h41,   1, 0, 1, 3,  32'h31,   1);
    vecs[3]  = mk(1, 3, 32'h32,   1, 4, 32'h41,   0, 1, 1, 4,  32'h41,   1);
    vecs[4]  = mk(0, 0, 32'h0,    0, 0, 32'h0,    0, 0, 0, 4,  32'h41,   1);
    vecs[5]  = mk(1, 0, 32'hDEAD, 0, 0, 32'h0,    1, 0, 0, 0,  32'h0,    0);
    vecs[6]  = mk(1, 5, 32'h55,   1, 6, 32'h66,   0, 1, 1, 6,  32'h66,   1);
    vecs[7]  = mk(1, 5, 32'h55,   0, 0, 32'h0,    1, 0, 1, 5,  32'h55,   1);
    vecs[8]  = mk(0, 0, 32'h0,    1, 9, 32'h99,   0, 1, 1, 9,  32'h99,   1);
    vecs[9]  = mk(1, 10, 32'hAA,  0, 0, 32'h0,    1, 0, 1, 10, 32'hAA,   1);
    vecs[10] = mk(1, 7, 32'h1111, 1, 7, 32'h2222, 0, 1, 1, 7,  32'h2222, 1);
    vecs[11] = mk(1, 7, 32'h1111, 0, 0, 32'h0,    1, 0, 1, 7,  32'h1111, 1);
    vecs[12] = mk(0, 0, 32'h0,    0, 0, 32'h0,    0, 0, 0, 7,  32'h1111, 1);

    rst = 1'b1;
    init_req = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 32; i++) rf[i] = 32'hFFFF_FFFF;

    // Reset state, with a requester knocking
    repeat (2) @(posedge clk);
    #1;
    drive(1, 3, 32'h5, 1, 4, 32'h6);
    #1;
    chk("rst_we2", 32'(we2), 0);
    chk("rst_wa3", 32'(wa3), 0);
    chk("rst_wd3", wd3, 0);
    chk("rst_a_ready", 32'(a_ready), 0);
    chk("rst_b_ready", 32'(b_ready), 0);
    chk("rst_init_busy", 32'(init_busy), 1);
    chk("rst_stall", 32'(stall_cnt), 0);
    drive(0, 0, 0, 0, 0, 0);
    rst = 1'b0;

    // Initial zeroing sweep
    for (int k = 1; k <= 31; k++) begin
      @(posedge clk);
      #1;
      chk("init_we2", 32'(we2), 1);
      chk("init_wa3", 32'(wa3), 32'(k));
      chk("init_wd3", wd3, 0);
      chk("init_busy", 32'(init_busy), (k < 31) ? 32'd1 : 32'd0);
    end

    // Table-driven RUN traffic
    exp_stall = 0;
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].av, vecs[i].aa, vecs[i].ad, vecs[i].bv, vecs[i].ba, vecs[i].bd);
      #1;
      chk($sformatf("v%0d_a_ready", i), 32'(a_ready), 32'(vecs[i].ear));
      chk($sformatf("v%0d_b_ready", i), 32'(b_ready), 32'(vecs[i].ebr));
      if ((vecs[i].av && !vecs[i].ear) || (vecs[i].bv && !vecs[i].ebr)) exp_stall++;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_we2", i), 32'(we2), 32'(vecs[i].ewe));
      if (vecs[i].chk_data) begin
        chk($sformatf("v%0d_wa3", i), 32'(wa3), 32'(vecs[i].ewa));
        chk($sformatf("v%0d_wd3", i), wd3, vecs[i].ewd);
      end
      chk($sformatf("v%0d_stall", i), 32'(stall_cnt), 32'(exp_stall));
    end
    chk("rf7_final", rf[7], 32'h1111);
    chk("stall_after_table", 32'(stall_cnt), 6);

    // init_req in RUN while A is waiting
    drive(1, 12, 32'hC0, 0, 0, 0);
    init_req = 1'b1;
    #1;
    chk("ireq_a_ready", 32'(a_ready), 1);
    @(posedge clk);
    #1;
    init_req = 1'b0;
    chk("ireq_we2", 32'(we2), 1);
    chk("ireq_wa3", 32'(wa3), 12);
    chk("ireq_busy", 32'(init_busy), 1);
    for (int k = 1; k <= 31; k++) begin
      chk("reinit_a_ready", 32'(a_ready), 0);
      @(posedge clk);
      #1;
      chk("reinit_wa3", 32'(wa3), 32'(k));
    end
    chk("reinit_stall", 32'(stall_cnt), 6);
    chk("post_init_a_ready", 32'(a_ready), 1);
    @(posedge clk);
    #1;
    chk("post_init_wa3", 32'(wa3), 12);
    chk("post_init_wd3", wd3, 32'hC0);
    drive(0, 0, 0, 0, 0, 0);

    // Reset in the middle of a sweep
    init_req = 1'b1;
    @(posedge clk);
    #1;
    init_req = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("mid_init_wa3", 32'(wa3), 9);
    rst = 1'b1;
    #1;
    chk("mid_rst_we2", 32'(we2), 0);
    chk("mid_rst_wa3", 32'(wa3), 0);
    chk("mid_rst_stall", 32'(stall_cnt), 0);
    chk("mid_rst_busy", 32'(init_busy), 1);
    @(posedge clk);
    #1;
    chk("mid_rst_we2_hold", 32'(we2), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("restart_we2", 32'(we2), 1);
    chk("restart_wa3", 32'(wa3), 1);
    repeat (30) @(posedge clk);
    #1;
    chk("restart_last_wa3", 32'(wa3), 31);
    chk("restart_busy", 32'(init_busy), 0);

    // Stall counter saturation under a permanent tie
    drive(1, 1, 32'h1, 1, 2, 32'h2);
    repeat (65534) @(posedge clk);
    #1;
    chk("stall_fffe", 32'(stall_cnt), 32'hFFFE);
    repeat (3) @(posedge clk);
    #1;
    chk("stall_sat", 32'(stall_cnt), 32'hFFFF);
    drive(0, 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning the data width of the write port.
REQ-002 SHALL have parameter AW, default 5, meaning the register address width, giving 2**AW registers.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, rising-edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port init_req, input, 1 bit: one-cycle request to re-zero the register file.
REQ-006 SHALL have port init_busy, output, 1 bit: high while the INIT sweep runs.
REQ-007 SHALL have ports a_valid (in, 1), a_addr (in, AW), a_data (in, XLEN) and a_ready (out, 1): writeback requester A (ALU).
REQ-008 SHALL have ports b_valid (in, 1), b_addr (in, AW), b_data (in, XLEN) and b_ready (out, 1): writeback requester B (LSU).
REQ-009 SHALL have ports we2 (out, 1), wa3 (out, AW) and wd3 (out, XLEN): the register-file write port, all registered.
REQ-010 SHALL have port stall_cnt, output, 16 bits: saturating count of cycles a requester was blocked.

Function
REQ-011 SHALL implement FSM states INIT and RUN; rst forces INIT.
REQ-012 INIT SHALL write zero to addresses 1..2**AW-1, one per cycle in ascending order: we2=1, wa3=index, wd3=0.
REQ-013 After the cycle that writes index 2**AW-1, the FSM SHALL enter RUN, and init_busy SHALL fall in the same edge.
REQ-014 In RUN, init_req=1 SHALL move the FSM to INIT at the next edge, with index restarting at 1; init_req SHALL be ignored in INIT.
REQ-015 In INIT, a_ready and b_ready SHALL be 0.
REQ-016 In RUN, ready SHALL be combinational from valid, state and priority; a transfer occurs on valid&ready.
REQ-017 In RUN, at most one requester SHALL be granted per cycle: a lone valid requester is granted.
REQ-018 When both requesters are valid, the grant SHALL go to the requester not granted last; the last_grant register SHALL update on every transfer.
REQ-019 A transfer in cycle N SHALL produce we2=1, wa3=addr and wd3=data in cycle N+1, giving a latency of 1.
REQ-020 A transfer with addr=0 SHALL be accepted (ready high) and SHALL update last_grant, but SHALL drive we2=0.
REQ-021 In a RUN cycle with no transfer, we2 SHALL be 0; wa3 and wd3 SHALL hold their previous values.
REQ-022 stall_cnt SHALL increment by 1 per RUN cycle in which a_valid&!a_ready or b_valid&!b_ready holds; it counts once per cycle even if both are blocked.
REQ-023 stall_cnt SHALL saturate at 16'hFFFF and SHALL count nothing in INIT.
REQ-024 A requester SHALL hold valid/addr/data until ready; the arbiter SHALL not depend on valid deasserting.
REQ-025 When both requesters target the same address in one cycle, they SHALL be serialized in round-robin order: the later write lands last.

Reset
REQ-026 While rst=1, all outputs SHALL be: we2=0, wa3=0, wd3=0, a_ready=0, b_ready=0, init_busy=1, stall_cnt=0.
REQ-027 While rst=1, the INIT index SHALL be 1 and last_grant SHALL be B, so that A wins the first tie.
REQ-028 rst asserted mid-INIT or mid-RUN SHALL abort immediately; any accepted-but-unwritten transfer is discarded.
REQ-029 After rst deasserts, the first INIT write SHALL occur in the first cycle.

Verification
REQ-030 Release reset with AW=5 -> 31 consecutive cycles with we2=1 and wa3=1..31, wd3=0; init_busy falls after wa3=31; readiness begins next cycle.
REQ-031 In RUN, a_valid=b_valid=1 held for 4 cycles, a_addr=3, b_addr=4 -> grants A,B,A,B; wa3 sequence 3,4,3,4 one cycle later; stall_cnt=4.
REQ-032 a_valid=1, a_addr=0, a_data=32'hDEAD -> a_ready=1 and we2 stays 0 next cycle; on the next tie, B is granted first.
REQ-033 Both requesters target addr 7: A=32'h1111, B=32'h2222, after last grant A -> wd3 is 2222 then 1111; register 7 ends at 32'h1111.
REQ-034 init_req pulse in RUN while A is valid -> a_ready=0 for 31 cycles and stall_cnt advances by 0; A is granted the first cycle after INIT.
REQ-035 Assert rst at INIT index 10, release -> sweep restarts at wa3=1; stall_cnt=0; we2 is 0 while rst=1.
